// File: rtl/and_gate_sequencer_if.sv
// ---------------------------------------------------------------------------
// and_gate_sequencer_if
// Bundles the stimulus/check signals between the and_gate_sequencer and the
// and_gate under test (plus the start/result side used by the operator).
//
//   in_start     start request, honoured only while the sequencer is idle
//   in_y         gate output under test (and_gate.out_sum)
//   out_a/out_b  gate input drives (out_vec[1] / out_vec[0])
//   out_vec      current vector index 0..3
//   out_busy     high while vectors are being applied
//   out_done     one-cycle pulse at the end of a run
//   out_pass     last completed run had zero mismatches
//   out_err_cnt  mismatches in the current or last run (0..4)
//
// master: the sequencer side.  slave: the environment (gate + controller).
// ---------------------------------------------------------------------------
interface and_gate_sequencer_if;
  logic       in_start;
  logic       in_y;
  logic       out_a;
  logic       out_b;
  logic [1:0] out_vec;
  logic       out_busy;
  logic       out_done;
  logic       out_pass;
  logic [2:0] out_err_cnt;

  modport master (
    input  in_start, in_y,
    output out_a, out_b, out_vec, out_busy, out_done, out_pass, out_err_cnt
  );

  modport slave (
    output in_start, in_y,
    input  out_a, out_b, out_vec, out_busy, out_done, out_pass, out_err_cnt
  );
endinterface

// File: rtl/and_gate_sequencer.sv
// ---------------------------------------------------------------------------
// and_gate_sequencer
// On a start request, drives the two-input and_gate through vectors 00, 01,
// 10, 11, holding each for HOLD_CYCLES clocks. In the last cycle of each hold
// window the gate output is compared with the expected AND value; mismatches
// are counted. A one-cycle done pulse and a pass flag report the result.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   and_gate_sequencer_if.master (start, gate output, drives, results)
//
// Parameter:
//   HOLD_CYCLES  cycles each vector is held before sampling, 1..255
// ---------------------------------------------------------------------------
module and_gate_sequencer #(
  parameter int HOLD_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  and_gate_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // The counter only needs to reach HOLD_CYCLES-1; keep at least one bit so
  // HOLD_CYCLES = 1 still elaborates.
  localparam int              CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]       vec_q, vec_d;
  logic [2:0]       err_cnt_q, err_cnt_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Expected gate value for the vector currently applied.
  logic             expected_y;
  assign expected_y = vec_q[1] & vec_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      vec_q      <= 2'd0;
      err_cnt_q  <= 3'd0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      vec_q      <= vec_d;
      err_cnt_q  <= err_cnt_d;
      pass_q     <= pass_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    vec_d      = vec_q;
    err_cnt_d  = err_cnt_q;
    pass_d     = pass_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_start) begin
          state_d    = ST_DRIVE;
          hold_cnt_d = '0;
          vec_d      = 2'd0;
          err_cnt_d  = 3'd0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
        end
      end

      ST_DRIVE: begin
        busy_d = 1'b1;
        if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end else begin
          // Last cycle of the window: the gate has had the whole hold to settle.
          if (bus.in_y != expected_y) begin
            err_cnt_d = err_cnt_q + 3'd1;
          end
          if (vec_q == 2'd3) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // Uses the updated count so the final compare is included.
            pass_d  = (err_cnt_d == 3'd0);
          end else begin
            vec_d      = vec_q + 2'd1;
            hold_cnt_d = '0;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.out_a       = vec_q[1];
  assign bus.out_b       = vec_q[0];
  assign bus.out_vec     = vec_q;
  assign bus.out_busy    = busy_q;
  assign bus.out_done    = done_q;
  assign bus.out_pass    = pass_q;
  assign bus.out_err_cnt = err_cnt_q;

endmodule
